// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder exposing a 16x8 register file; optional write-frame counter at 0x7F via SPI_REG_RESPONDER_STATUS_EN.
// Latency: SYNC_STAGES+1 CLK from an SCLK edge to action; WR_STB 1 CLK after the 8th data bit, REG0 1 CLK later.
// Backpressure: none; the master paces everything, SCLK must stay <= CLK/8.
`timescale 1ns/1ps
module spi_reg_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] REG_INIT0   = 8'h00
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       SCLK,
    input  logic       CS_N,
    input  logic       MOSI,
    output logic       MISO,
    output logic [7:0] REG0,
    output logic       WR_STB,
    output logic [3:0] WR_ADDR,
    output logic [7:0] WR_DATA
);

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_s, cs_s, mosi_s, sclk_d, cs_d;
    logic                   sclk_rise, sclk_fall, cs_fall, byte_done;
    logic [2:0]             bit_cnt;
    logic [6:0]             shift_in;
    logic [7:0]             shift_out, rx_byte, rd_byte;
    logic [6:0]             addr, rd_addr;
    logic [7:0]             regs [16];

    // CS sync resets to "selected" so a frame already running at reset release is never seen as a new fall
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_N};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = cs_d & ~cs_s;
    assign rx_byte   = {shift_in, mosi_s};
    assign byte_done = (state != IDLE) && !cs_s && sclk_rise && (bit_cnt == 3'd7);
    assign REG0      = regs[0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = CMD;
            CMD:     if (byte_done) state_nxt = rx_byte[7] ? RDATA : WDATA;
            default: state_nxt = state;
        endcase
        if (cs_s) state_nxt = IDLE;
    end

`ifdef SPI_REG_RESPONDER_STATUS_EN
    logic [7:0] wr_frames;
    logic       frame_wrote;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_frames   <= 8'h00;
            frame_wrote <= 1'b0;
        end else begin
            if (state == IDLE)
                frame_wrote <= 1'b0;
            else if (state == WDATA && byte_done)
                frame_wrote <= 1'b1;
            if (state == WDATA && cs_s && frame_wrote)
                wr_frames <= wr_frames + 8'd1;
        end
    end
`endif

    // The command byte's address is needed in the same cycle the command completes
    always_comb begin
        rd_addr = (state == CMD) ? rx_byte[6:0] : addr;
        rd_byte = 8'h00;
        if (rd_addr[6:4] == 3'd0)
            rd_byte = regs[rd_addr[3:0]];
`ifdef SPI_REG_RESPONDER_STATUS_EN
        else if (rd_addr == 7'h7F)
            rd_byte = wr_frames;
`endif
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bit_cnt   <= 3'd0;
            shift_in  <= 7'd0;
            shift_out <= 8'h00;
            addr      <= 7'd0;
            MISO      <= 1'b0;
            WR_STB    <= 1'b0;
            WR_ADDR   <= 4'd0;
            WR_DATA   <= 8'h00;
            for (int i = 1; i < 16; i++) regs[i] <= 8'h00;
            regs[0] <= REG_INIT0;
        end else begin
            WR_STB <= 1'b0;
            if (WR_STB) regs[WR_ADDR] <= WR_DATA;
            if (cs_s || state == IDLE) begin
                bit_cnt   <= 3'd0;
                shift_in  <= 7'd0;
                shift_out <= 8'h00;
                MISO      <= 1'b0;
            end else if (sclk_rise) begin
                shift_in <= rx_byte[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    case (state)
                        CMD: begin
                            if (rx_byte[7]) begin
                                shift_out <= rd_byte;
                                addr      <= rx_byte[6:0] + 7'd1;
                            end else begin
                                addr      <= rx_byte[6:0];
                            end
                        end
                        WDATA: begin
                            if (addr[6:4] == 3'd0) begin
                                WR_STB  <= 1'b1;
                                WR_ADDR <= addr[3:0];
                                WR_DATA <= rx_byte;
                            end
                            addr <= addr + 7'd1;
                        end
                        RDATA: begin
                            shift_out <= rd_byte;
                            addr      <= addr + 7'd1;
                        end
                        default: ;
                    endcase
                end
            end else if (sclk_fall) begin
                MISO      <= shift_out[7];
                shift_out <= {shift_out[6:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Randomized scoreboard bench for spi_reg_responder: a byte-level frame model predicts
// WR_STB events and MISO bytes, and a monitor compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_spi_reg_responder;

    localparam logic [7:0] INIT0 = 8'h3C;
    localparam int HALF = 80;

    logic       CLK = 1'b0, RST_N = 1'b0, SCLK = 1'b0, CS_N = 1'b1, MOSI = 1'b0;
    logic       MISO, WR_STB;
    logic [7:0] REG0, WR_DATA;
    logic [3:0] WR_ADDR;

    spi_reg_responder #(.SYNC_STAGES(2), .REG_INIT0(INIT0)) dut (
        .CLK(CLK), .RST_N(RST_N), .SCLK(SCLK), .CS_N(CS_N), .MOSI(MOSI),
        .MISO(MISO), .REG0(REG0), .WR_STB(WR_STB), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA)
    );

    always #5 CLK = ~CLK;

    typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_t;

    int          checks = 0, errors = 0;
    wr_t         wr_exp[$];
    logic [7:0]  rd_exp[$], rx_got[$];
    logic [7:0]  m_regs[16];
    int unsigned m_cnt;
    logic [7:0]  tx[0:31];
    wr_t         mon_e;
    logic [7:0]  mon_got, mon_exp, reg0_exp;
    logic        reg0_pend = 1'b0;

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%02h expected=%02h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [6:0] a);
        if (a < 7'd16) return m_regs[a[3:0]];
`ifdef SPI_REG_RESPONDER_STATUS_EN
        if (a == 7'h7F) return m_cnt[7:0];
`endif
        return 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_regs[0] = INIT0;
        m_cnt = 0;
    endtask

    // Predict one frame: bytes completed before any reset take effect, later ones read as zero
    task automatic model_frame(input int nbits, input int rst_bit);
        int nfull;
        logic rd;
        logic [6:0] a;
        nfull = (rst_bit >= 0) ? rst_bit / 8 : nbits / 8;
        rd = 1'b0;
        a  = 7'd0;
        if (nfull >= 1) begin
            rd = tx[0][7];
            a  = tx[0][6:0];
            rd_exp.push_back(8'h00);
        end
        for (int i = 1; i < nfull; i++) begin
            if (rd) begin
                rd_exp.push_back(m_read(a));
            end else begin
                rd_exp.push_back(8'h00);
                if (a < 7'd16) begin
                    m_regs[a[3:0]] = tx[i];
                    wr_exp.push_back({a[3:0], tx[i]});
                end
            end
            a = a + 7'd1;
        end
        if (rst_bit >= 0) begin
            model_reset();
            for (int i = nfull; i < nbits / 8; i++) rd_exp.push_back(8'h00);
        end else if (!rd && nfull >= 2) begin
            m_cnt = (m_cnt + 1) % 256;
        end
    endtask

    task automatic spi_xfer(input int nbits, input int rst_bit);
        logic [7:0] cap;
        cap = 8'h00;
        CS_N = 1'b0;
        #(2*HALF);
        for (int k = 0; k < nbits; k++) begin
            if (k == rst_bit) begin
                RST_N = 1'b0;
                #30;
                RST_N = 1'b1;
                #20;
            end
            MOSI = tx[k/8][7-(k%8)];
            #HALF SCLK = 1'b1;
            cap = {cap[6:0], MISO};
            if (k % 8 == 7) rx_got.push_back(cap);
            #HALF SCLK = 1'b0;
        end
        #(2*HALF) CS_N = 1'b1;
        MOSI = 1'b0;
        #400;
    endtask

    task automatic run(input int nbits, input int rst_bit);
        model_frame(nbits, rst_bit);
        spi_xfer(nbits, rst_bit);
        check8("reg0_after_frame", REG0, m_regs[0]);
        check8("miso_idle", {7'd0, MISO}, 8'h00);
    endtask

    always @(negedge CLK) begin
        if (RST_N) begin
            if (reg0_pend) begin
                check8("reg0_cycle_after_stb", REG0, reg0_exp);
                reg0_pend = 1'b0;
            end
            if (WR_STB) begin
                if (wr_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wr_stb got addr=%0h data=%02h expected no strobe", WR_ADDR, WR_DATA);
                end else begin
                    mon_e = wr_exp.pop_front();
                    check8("wr_addr", {4'h0, WR_ADDR}, {4'h0, mon_e.a});
                    check8("wr_data", WR_DATA, mon_e.d);
                    if (mon_e.a == 4'h0) begin
                        reg0_pend = 1'b1;
                        reg0_exp  = mon_e.d;
                    end
                end
            end
            while (rx_got.size() > 0) begin
                mon_got = rx_got.pop_front();
                if (rd_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL miso_byte got=%02h expected nothing queued", mon_got);
                end else begin
                    mon_exp = rd_exp.pop_front();
                    check8("miso_byte", mon_got, mon_exp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int nbytes, r;
        logic [6:0] a;
        model_reset();
        #12;
        check8("reset_reg0", REG0, INIT0);
        check8("reset_miso", {7'd0, MISO}, 8'h00);
        check8("reset_wr_stb", {7'd0, WR_STB}, 8'h00);
        check8("reset_wr_addr", {4'd0, WR_ADDR}, 8'h00);
        check8("reset_wr_data", WR_DATA, 8'h00);
        #21 RST_N = 1'b1;
        #200;

        tx[0] = 8'h03; tx[1] = 8'hA5; run(16, -1);
        tx[0] = 8'h83; tx[1] = 8'h00; run(16, -1);
        tx[0] = 8'h0E; tx[1] = 8'h11; tx[2] = 8'h22; tx[3] = 8'h33; run(32, -1);
        tx[0] = 8'h8E; tx[1] = 8'h00; tx[2] = 8'h00; tx[3] = 8'h00; run(32, -1);
        tx[0] = 8'h00; tx[1] = 8'h5A; run(16, -1);
        tx[0] = 8'h80; tx[1] = 8'h00; tx[2] = 8'h00; run(24, -1);
        tx[0] = 8'h04; tx[1] = 8'hFF; run(11, -1);
        tx[0] = 8'h05; run(8, -1);
        tx[0] = 8'h85; run(8, -1);
        tx[0] = 8'h84; tx[1] = 8'h00; run(16, -1);

        for (int n = 0; n < 24; n++) begin
            nbytes = $urandom_range(1, 5);
            r = $urandom_range(0, 7);
            if (r < 5)       a = 7'($urandom_range(0, 15));
            else if (r == 5) a = 7'($urandom_range(12, 19));
            else if (r == 6) a = 7'h7F;
            else             a = 7'($urandom_range(0, 127));
            tx[0] = {1'($urandom_range(0, 1)), a};
            for (int i = 1; i < nbytes; i++) tx[i] = 8'($urandom_range(0, 255));
            run(nbytes * 8 + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0), -1);
        end

        tx[0] = 8'h01; tx[1] = 8'h77; tx[2] = 8'h99; run(24, 20);
        tx[0] = 8'h80;
        for (int i = 1; i <= 16; i++) tx[i] = 8'h00;
        run(136, -1);
        tx[0] = 8'h02; tx[1] = 8'h44; run(16, -1);
        tx[0] = 8'h7F; tx[1] = 8'h12; run(16, -1);
        tx[0] = 8'h0F; tx[1] = 8'hC3; tx[2] = 8'h3C; run(24, -1);
        tx[0] = 8'hFF; tx[1] = 8'h00; run(16, -1);
        tx[0] = 8'h8F; tx[1] = 8'h00; tx[2] = 8'h00; run(24, -1);

        #200;
        checks++;
        if (wr_exp.size() != 0) begin
            errors++;
            $display("FAIL wr_exp_drained got=%0d pending expected=0", wr_exp.size());
        end
        checks++;
        if (rd_exp.size() != 0) begin
            errors++;
            $display("FAIL rd_exp_drained got=%0d pending expected=0", rd_exp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
